// File: rtl/flag_stream_checker_pkg.sv
// ============================================================================
// Package     : flag_pkg
// Description : Shared types and obfuscated expected-string ROM for the flag
//               stream checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    FULL  = 2'd2,
    FAIL  = 2'd3
  } chk_state_t;

  localparam int FLAG_MAX = 64;

  // Each entry is the expected ASCII byte XORed with the key (7'h2A).
  localparam logic [6:0] FLAG_ROM [FLAG_MAX] = '{
    7'h69, 7'h7E, 7'h6C, 7'h51, 7'h59, 7'h5E, 7'h58, 7'h19,
    7'h1E, 7'h47, 7'h75, 7'h49, 7'h42, 7'h19, 7'h49, 7'h41,
    7'h19, 7'h58, 7'h75, 7'h52, 7'h1A, 7'h58, 7'h75, 7'h58,
    7'h1A, 7'h47, 7'h75, 7'h5D, 7'h1B, 7'h44, 7'h59, 7'h75,
    7'h4C, 7'h46, 7'h1E, 7'h4D, 7'h75, 7'h4E, 7'h1A, 7'h44,
    7'h4F, 7'h75, 7'h45, 7'h41, 7'h75, 7'h45, 7'h41, 7'h0B,
    7'h57, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

endpackage

`default_nettype wire

// File: rtl/flag_stream_checker_rom.sv
// ============================================================================
// Module      : flag_rom
// Description : Combinational lookup of the de-obfuscated expected byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_rom
  import flag_pkg::*;
#(
  parameter int         FLAG_LEN = 49,
  parameter logic [6:0] KEY      = 7'h2A,
  parameter int         IDX_W    = 6
) (
  input  logic [IDX_W-1:0] addr,
  output logic [6:0]       data
);

  logic [5:0] w_idx;

  assign w_idx = 6'(addr);

  // Addresses at or beyond the string length read as zero, not as KEY.
  always_comb begin
    data = 7'h00;
    if (int'(addr) < FLAG_LEN) begin
      data = FLAG_ROM[w_idx] ^ KEY;
    end
  end

endmodule

`default_nettype wire

// File: rtl/flag_stream_checker.sv
// ============================================================================
// Module      : flag_stream_checker
// Description : In-order byte comparator against the ROM string; win when
//               exactly FLAG_LEN bytes matched, sticky fail otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_stream_checker
  import flag_pkg::*;
#(
  parameter int         FLAG_LEN = 49,
  parameter logic [6:0] KEY      = 7'h2A,
  parameter int         IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       next_byte,
  input  logic             clr,
  output logic             win,
  output logic             fail,
  output logic [IDX_W-1:0] count
);

  localparam logic [IDX_W-1:0] c_COUNT_FULL = IDX_W'(FLAG_LEN);
  localparam logic [IDX_W-1:0] c_COUNT_SAT  = IDX_W'(FLAG_LEN + 1);

  chk_state_t       r_state;
  logic [IDX_W-1:0] r_count;
  logic             r_win;
  logic             r_fail;
  logic [6:0]       w_expected;
  logic             w_match;
  logic [IDX_W-1:0] w_count_inc;

  flag_rom #(
    .FLAG_LEN (FLAG_LEN),
    .KEY      (KEY),
    .IDX_W    (IDX_W)
  ) u_rom (
    .addr (r_count),
    .data (w_expected)
  );

  assign w_match     = (next_byte == w_expected);
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_win   <= 1'b0;
      r_fail  <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_count <= '0;
      r_win   <= 1'b0;
      r_fail  <= 1'b0;
    end else if (en) begin
      if (r_count != c_COUNT_SAT) begin
        r_count <= w_count_inc;
      end
      // In IDLE the count is zero, so the same compare serves both states.
      case (r_state)
        IDLE, MATCH: begin
          if (!w_match) begin
            r_state <= FAIL;
            r_fail  <= 1'b1;
          end else if (w_count_inc == c_COUNT_FULL) begin
            r_state <= FULL;
            r_win   <= 1'b1;
          end else begin
            r_state <= MATCH;
          end
        end
        FULL: begin
          r_state <= FAIL;
          r_win   <= 1'b0;
          r_fail  <= 1'b1;
        end
        default: begin
          r_state <= FAIL;
          r_fail  <= 1'b1;
        end
      endcase
    end
  end

  assign win   = r_win;
  assign fail  = r_fail;
  assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_flag_stream_checker.sv
// ============================================================================
// Module      : tb_flag_stream_checker
// Description : Self-checking bench for flag_stream_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_stream_checker;
  import flag_pkg::*;

  localparam int FLAG_LEN = 49;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] next_byte = 7'h00;
  logic       win;
  logic       fail;
  logic [5:0] count;

  flag_stream_checker #(
    .FLAG_LEN (FLAG_LEN),
    .KEY      (7'h2A),
    .IDX_W    (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .next_byte (next_byte),
    .clr       (clr),
    .win       (win),
    .fail      (fail),
    .count     (count)
  );

  always #5 clk = ~clk;

  string c_flag = "CTF{str34m_ch3ck3r_x0r_r0m_w1ns_fl4g_d0ne_ok_ok!}";

  typedef struct {
    bit         w;
    bit         f;
    logic [5:0] c;
    string      tag;
  } exp_t;

  typedef struct {
    bit         e;
    bit         c;
    logic [6:0] b;
    bit         w;
    bit         f;
    logic [5:0] cnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_count = 0;
  bit   m_bad = 1'b0;

  function automatic logic [6:0] flag_byte(input int i);
    byte t;
    t = c_flag[i];
    return t[6:0];
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the negedge, queue its expectation, compare after the edge.
  task automatic drive(input bit e, input bit c, input logic [6:0] b,
                       input bit ew, input bit ef, input logic [5:0] ec, input string tag);
    exp_t x;
    @(negedge clk);
    en = e; clr = c; next_byte = b;
    sb_q.push_back('{w: ew, f: ef, c: ec, tag: tag});
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
    if (sb_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s_sb: got empty queue expected entry", tag);
    end else begin
      x = sb_q.pop_front();
      check({x.tag, "_win"},   7'(win),   7'(x.w));
      check({x.tag, "_fail"},  7'(fail),  7'(x.f));
      check({x.tag, "_count"}, 7'(count), 7'(x.c));
    end
  endtask

  task automatic mstep(input bit e, input bit c, input logic [6:0] b, input string tag);
    if (c) begin
      m_count = 0; m_bad = 1'b0;
    end else if (e) begin
      if (m_count >= FLAG_LEN) m_bad = 1'b1;
      else if (b != flag_byte(m_count)) m_bad = 1'b1;
      if (m_count < FLAG_LEN + 1) m_count++;
    end
    drive(e, c, b, !m_bad && (m_count == FLAG_LEN), m_bad, 6'(m_count), tag);
  endtask

  // Reset asserted between edges so the outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_rst_win"},   7'(win),   7'h0);
    check({tag, "_rst_fail"},  7'(fail),  7'h0);
    check({tag, "_rst_count"}, 7'(count), 7'h0);
    @(negedge clk);
    rst = 1'b0;
    m_count = 0; m_bad = 1'b0;
  endtask

  task automatic stream(input int n, input int bad_idx, input logic [6:0] bad_b,
                        input int max_gap, input string tag);
    logic [6:0] b;
    for (int i = 0; i < n; i++) begin
      b = (i == bad_idx) ? bad_b : flag_byte(i);
      mstep(1'b1, 1'b0, b, tag);
      if (max_gap > 0) begin
        repeat ($urandom_range(1, max_gap)) mstep(1'b0, 1'b0, 7'($urandom), {tag, "_gap"});
      end
    end
  endtask

  initial begin
    tbl[0] = '{e: 0, c: 0, b: 7'h43, w: 0, f: 0, cnt: 6'd0};
    tbl[1] = '{e: 1, c: 0, b: 7'h43, w: 0, f: 0, cnt: 6'd1};
    tbl[2] = '{e: 1, c: 0, b: 7'h54, w: 0, f: 0, cnt: 6'd2};
    tbl[3] = '{e: 0, c: 0, b: 7'h58, w: 0, f: 0, cnt: 6'd2};
    tbl[4] = '{e: 1, c: 0, b: 7'h66, w: 0, f: 1, cnt: 6'd3};
    tbl[5] = '{e: 1, c: 0, b: 7'h46, w: 0, f: 1, cnt: 6'd4};
    tbl[6] = '{e: 1, c: 1, b: 7'h43, w: 0, f: 0, cnt: 6'd0};
    tbl[7] = '{e: 1, c: 0, b: 7'h43, w: 0, f: 0, cnt: 6'd1};
    tbl[8] = '{e: 0, c: 1, b: 7'h00, w: 0, f: 0, cnt: 6'd0};
    tbl[9] = '{e: 1, c: 0, b: 7'h5A, w: 0, f: 1, cnt: 6'd1};

    do_reset("tbl");
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].e, tbl[i].c, tbl[i].b, tbl[i].w, tbl[i].f, tbl[i].cnt,
            $sformatf("tbl%0d", i));
    end

    do_reset("t1");
    stream(FLAG_LEN, -1, 7'h00, 0, "t1");
    check("t1_final_win", 7'(win), 7'h1);
    check("t1_final_fail", 7'(fail), 7'h0);
    check("t1_final_count", 7'(count), 7'd49);

    do_reset("t2");
    stream(FLAG_LEN - 1, -1, 7'h00, 0, "t2");
    check("t2_final_win", 7'(win), 7'h0);
    check("t2_final_count", 7'(count), 7'd48);
    check("t2_state", 7'(dut.r_state), 7'(MATCH));

    do_reset("t3");
    stream(FLAG_LEN, 5, 7'h58, 0, "t3");
    check("t3_final_win", 7'(win), 7'h0);
    check("t3_final_fail", 7'(fail), 7'h1);
    check("t3_final_count", 7'(count), 7'd49);

    do_reset("t4");
    stream(FLAG_LEN, -1, 7'h00, 0, "t4");
    check("t4_full_win", 7'(win), 7'h1);
    mstep(1'b1, 1'b0, 7'h41, "t4_extra");
    check("t4_extra_win", 7'(win), 7'h0);
    check("t4_extra_fail", 7'(fail), 7'h1);
    check("t4_extra_count", 7'(count), 7'd50);
    mstep(1'b1, 1'b0, 7'h41, "t4_sat");
    mstep(1'b1, 1'b0, 7'h41, "t4_sat");
    check("t4_sat_count", 7'(count), 7'd50);

    do_reset("t5");
    stream(20, -1, 7'h00, 0, "t5a");
    check("t5_mid_count", 7'(count), 7'd20);
    do_reset("t5_mid");
    stream(FLAG_LEN, -1, 7'h00, 0, "t5b");
    check("t5_final_win", 7'(win), 7'h1);

    do_reset("t6");
    stream(FLAG_LEN, -1, 7'h00, 3, "t6");
    check("t6_final_win", 7'(win), 7'h1);
    check("t6_final_count", 7'(count), 7'd49);
    mstep(1'b1, 1'b1, flag_byte(0), "t6_clr");
    check("t6_clr_count", 7'(count), 7'd0);
    check("t6_clr_win", 7'(win), 7'h0);
    mstep(1'b1, 1'b0, flag_byte(0), "t6_after");
    check("t6_after_count", 7'(count), 7'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
